rc4_sequencer: RTL and testbench

RC4_SEQUENCER -- requirements
Module: rc4_sequencer

---
 rtl/rc4_pkg.sv | 34 +++
 rtl/phase_timer.sv | 49 ++++
 rtl/rc4_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rc4_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared types and constants for the RC4 phase sequencer.
//   state_e   : sequencer FSM states
//   PH_*      : encoding of the S-memory owner shown on the phase output
//   byte_t    : 8-bit address/data byte
//   TIMER_W   : width of the per-phase watchdog timer
//   is_run()  : true for the three states in which an engine owns the S RAM
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_KSA_GO,
    ST_KSA_RUN,
    ST_PRGA_GO,
    ST_PRGA_RUN,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [1:0] PH_NONE = 2'b00;
  localparam logic [1:0] PH_INIT = 2'b01;
  localparam logic [1:0] PH_KSA  = 2'b10;
  localparam logic [1:0] PH_PRGA = 2'b11;

  localparam int TIMER_W = 16;

  function automatic logic is_run(input state_e s);
    return (s == ST_INIT_RUN) || (s == ST_KSA_RUN) || (s == ST_PRGA_RUN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer -- per-phase watchdog counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : force the count to zero on the next edge
//   en_i         : count one per cycle (saturating, never wraps)
//   count_o      : current count (0 during the first cycle after a clear)
//   expired_o    : the count reaches TIMEOUT on the coming edge while enabled
module phase_timer
  import rc4_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               expired_o
);

  localparam logic [TIMER_W-1:0] MAX = '1;
  // Flag one cycle early so the owner leaves its run state exactly TIMEOUT
  // cycles after entering it.
  localparam logic [TIMER_W-1:0] LIMIT = (TIMEOUT <= 1)     ? '0  :
                                         (TIMEOUT > 65536)  ? MAX :
                                         TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = en_i && (count_q >= LIMIT);

endmodule

// File: rtl/rc4_sequencer.sv
// rc4_sequencer -- runs the RC4 init -> KSA -> PRGA engines in order and
// grants the shared S RAM port to whichever engine currently owns it.
//   start, abort                 : sequence request / forced return to idle
//   init/ksa/prga_start          : one-cycle engine start pulses (registered)
//   init/ksa/prga_finish         : engine completion levels
//   init/ksa/prga_addr/data/wen  : engine S RAM requests
//   s_addr, s_data, s_wen        : granted S RAM request
//   phase                        : current memory owner (PH_*)
//   busy, done, error            : status; error is a sticky phase timeout
module rc4_sequencer
  import rc4_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  output logic       init_start,
  output logic       ksa_start,
  output logic       prga_start,
  input  logic       init_finish,
  input  logic       ksa_finish,
  input  logic       prga_finish,
  input  byte_t      init_addr,
  input  byte_t      init_data,
  input  byte_t      ksa_addr,
  input  byte_t      ksa_data,
  input  byte_t      prga_addr,
  input  byte_t      prga_data,
  input  logic       init_wen,
  input  logic       ksa_wen,
  input  logic       prga_wen,
  output byte_t      s_addr,
  output byte_t      s_data,
  output logic       s_wen,
  output logic [1:0] phase,
  output logic       busy,
  output logic       done,
  output logic       error
);

  state_e             state_q;
  logic [1:0]         phase_q;
  logic               init_start_q, ksa_start_q, prga_start_q;
  logic               done_q, error_q, busy_q;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_expired;
  logic               in_run, in_go;
  logic               cur_finish, finish_seen;

  assign in_run = is_run(state_q);
  assign in_go  = (state_q == ST_INIT_GO) || (state_q == ST_KSA_GO) ||
                  (state_q == ST_PRGA_GO);

  phase_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (in_go),
    .en_i      (in_run),
    .count_o   (timer_count),
    .expired_o (timer_expired)
  );

  // The timer was cleared in the GO cycle, so a zero count marks the first
  // run cycle, where a finish level left over from a previous run is ignored.
  always_comb begin
    cur_finish = 1'b0;
    case (state_q)
      ST_INIT_RUN: cur_finish = init_finish;
      ST_KSA_RUN:  cur_finish = ksa_finish;
      ST_PRGA_RUN: cur_finish = prga_finish;
      default:     cur_finish = 1'b0;
    endcase
  end

  assign finish_seen = cur_finish && (timer_count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_NONE;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      prga_start_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      prga_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort) begin
        // Abort wins over everything but leaves a pending error visible.
        state_q <= ST_IDLE;
        phase_q <= PH_NONE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_ERROR: begin
            if (start) begin
              state_q      <= ST_INIT_GO;
              phase_q      <= PH_INIT;
              init_start_q <= 1'b1;
              busy_q       <= 1'b1;
              error_q      <= 1'b0;
            end
          end
          ST_INIT_GO: state_q <= ST_INIT_RUN;
          ST_KSA_GO:  state_q <= ST_KSA_RUN;
          ST_PRGA_GO: state_q <= ST_PRGA_RUN;
          ST_INIT_RUN, ST_KSA_RUN, ST_PRGA_RUN: begin
            if (finish_seen) begin
              case (state_q)
                ST_INIT_RUN: begin
                  state_q     <= ST_KSA_GO;
                  phase_q     <= PH_KSA;
                  ksa_start_q <= 1'b1;
                end
                ST_KSA_RUN: begin
                  state_q      <= ST_PRGA_GO;
                  phase_q      <= PH_PRGA;
                  prga_start_q <= 1'b1;
                end
                default: begin
                  state_q <= ST_DONE;
                  phase_q <= PH_NONE;
                  done_q  <= 1'b1;
                end
              endcase
            end else if (timer_expired) begin
              state_q <= ST_ERROR;
              phase_q <= PH_NONE;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            phase_q <= PH_NONE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Grant mux: only the engine named by phase can reach the RAM, and only
  // while it is actually running.
  always_comb begin
    s_addr = '0;
    s_data = '0;
    s_wen  = 1'b0;
    if (in_run) begin
      case (phase_q)
        PH_INIT: begin s_addr = init_addr; s_data = init_data; s_wen = init_wen; end
        PH_KSA:  begin s_addr = ksa_addr;  s_data = ksa_data;  s_wen = ksa_wen;  end
        PH_PRGA: begin s_addr = prga_addr; s_data = prga_data; s_wen = prga_wen; end
        default: begin s_addr = '0; s_data = '0; s_wen = 1'b0; end
      endcase
    end
  end

  assign init_start = init_start_q;
  assign ksa_start  = ksa_start_q;
  assign prga_start = prga_start_q;
  assign phase      = phase_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_rc4_sequencer.sv
module tb_rc4_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, start_t, abort_t;
  logic [7:0] eng_addr [3];
  logic [7:0] eng_data [3];
  logic       eng_wen  [3];
  logic       fin      [3];
  logic       fin_t    [3];

  logic       init_start, ksa_start, prga_start, s_wen, busy, done, error;
  logic [7:0] s_addr, s_data;
  logic [1:0] phase;
  logic       init_start_t, ksa_start_t, prga_start_t, s_wen_t, busy_t, done_t, error_t;
  logic [7:0] s_addr_t, s_data_t;
  logic [1:0] phase_t;

  int tests, fails;
  int eng_cnt [3];
  int eng_dly [3];
  bit auto_eng;

  always #5 clk = ~clk;

  rc4_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_finish(fin[0]), .ksa_finish(fin[1]), .prga_finish(fin[2]),
    .init_addr(eng_addr[0]), .init_data(eng_data[0]),
    .ksa_addr(eng_addr[1]), .ksa_data(eng_data[1]),
    .prga_addr(eng_addr[2]), .prga_data(eng_data[2]),
    .init_wen(eng_wen[0]), .ksa_wen(eng_wen[1]), .prga_wen(eng_wen[2]),
    .s_addr(s_addr), .s_data(s_data), .s_wen(s_wen),
    .phase(phase), .busy(busy), .done(done), .error(error)
  );

  rc4_sequencer #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .start(start_t), .abort(abort_t),
    .init_start(init_start_t), .ksa_start(ksa_start_t), .prga_start(prga_start_t),
    .init_finish(fin_t[0]), .ksa_finish(fin_t[1]), .prga_finish(fin_t[2]),
    .init_addr(eng_addr[0]), .init_data(eng_data[0]),
    .ksa_addr(eng_addr[1]), .ksa_data(eng_data[1]),
    .prga_addr(eng_addr[2]), .prga_data(eng_data[2]),
    .init_wen(eng_wen[0]), .ksa_wen(eng_wen[1]), .prga_wen(eng_wen[2]),
    .s_addr(s_addr_t), .s_data(s_data_t), .s_wen(s_wen_t),
    .phase(phase_t), .busy(busy_t), .done(done_t), .error(error_t)
  );

  // {init_start, ksa_start, prga_start, done, busy, error, phase, s_wen, s_addr, s_data}
  function automatic logic [24:0] pk(input logic is, input logic ks, input logic ps,
                                     input logic dn, input logic bs, input logic er,
                                     input logic [1:0] ph, input logic w,
                                     input logic [7:0] a, input logic [7:0] d);
    return {is, ks, ps, dn, bs, er, ph, w, a, d};
  endfunction

  function automatic logic [24:0] obs_m();
    return pk(init_start, ksa_start, prga_start, done, busy, error, phase, s_wen, s_addr, s_data);
  endfunction

  function automatic logic [24:0] obs_t();
    return pk(init_start_t, ksa_start_t, prga_start_t, done_t, busy_t, error_t, phase_t,
              s_wen_t, s_addr_t, s_data_t);
  endfunction

  // Engine model: finish drops when its start pulse is seen and rises a fixed
  // number of cycles later; request buses carry random traffic every cycle.
  task automatic eng_update();
    logic st [3];
    st[0] = init_start; st[1] = ksa_start; st[2] = prga_start;
    for (int x = 0; x < 3; x++) begin
      if (auto_eng) begin
        if (st[x]) begin
          eng_cnt[x] = eng_dly[x];
          fin[x] = 1'b0;
        end else if (eng_cnt[x] > 0) begin
          eng_cnt[x]--;
          if (eng_cnt[x] == 0) fin[x] = 1'b1;
        end
      end
      eng_addr[x] = 8'($urandom);
      eng_data[x] = 8'($urandom);
      eng_wen[x]  = 1'($urandom);
    end
  endtask

  // Full sequence with engine delays di/dk/dp (each >= 2). With start sampled
  // at the end of cycle 0, init_start shows in cycle 1 and each next pulse
  // appears delay+1 cycles after the previous one.
  task automatic run_sequence(input int di, input int dk, input int dp,
                              input bit noise, input bit immediate, input string tag);
    int gi, gk, gp, gd, nbad;
    logic [1:0] ph;
    logic run, ew;
    logic [7:0] ea, ed;
    logic [24:0] exp_v, act_v;
    eng_dly[0] = di; eng_dly[1] = dk; eng_dly[2] = dp;
    eng_cnt = '{0, 0, 0};
    auto_eng = 1'b1;
    gi = 1; gk = gi + di + 1; gp = gk + dk + 1; gd = gp + dp + 1;
    nbad = 0;
    if (!immediate) @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= gd + 2; c++) begin
      @(negedge clk);
      ph = (c >= gi && c < gk) ? 2'd1 : (c >= gk && c < gp) ? 2'd2 :
           (c >= gp && c < gd) ? 2'd3 : 2'd0;
      run = (ph != 2'd0) && (c != gi) && (c != gk) && (c != gp);
      ew = 1'b0; ea = 8'h00; ed = 8'h00;
      if (run) begin
        ew = eng_wen[int'(ph) - 1];
        ea = eng_addr[int'(ph) - 1];
        ed = eng_data[int'(ph) - 1];
      end
      exp_v = pk(c == gi, c == gk, c == gp, c == gd, c <= gd, 1'b0, ph, ew, ea, ed);
      act_v = obs_m();
      tests++;
      if (act_v !== exp_v) begin
        fails++; nbad++;
        $display("FAIL %s cycle %0d: got %h, expected %h", tag, c, act_v, exp_v);
      end
      eng_update();
      start = (noise && c <= gd) ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    $display("[TB] %s: delays %0d/%0d/%0d, done expected at cycle %0d, %0d bad cycles",
             tag, di, dk, dp, gd, nbad);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({obs_m(), obs_t()} !== 50'd0) begin
      fails++;
      $display("FAIL reset_state: got %h/%h, expected all zero", obs_m(), obs_t());
    end
    reset_n = 1'b1;
    $display("[TB] reset: outputs checked while reset held");
  endtask

  task automatic test_normal_run();
    run_sequence(257, 770, 1200, 1'b0, 1'b0, "normal_run");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++)
      run_sequence($urandom_range(2, 40), $urandom_range(2, 40), $urandom_range(2, 40),
                   1'b1, (r != 0), "back_to_back");
  endtask

  task automatic test_stale_finish();
    logic [24:0] e;
    auto_eng = 1'b0;
    fin = '{1'b1, 1'b0, 1'b0};
    eng_addr = '{8'h10, 8'h55, 8'h77};
    eng_data = '{8'ha1, 8'hb2, 8'hc3};
    eng_wen  = '{1'b1, 1'b1, 1'b1};
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1:       e = pk(1, 0, 0, 0, 1, 0, 2'd1, 0, 8'h00, 8'h00);
        2, 3:    e = pk(0, 0, 0, 0, 1, 0, 2'd1, 1, 8'h10, 8'ha1);
        4:       e = pk(0, 1, 0, 0, 1, 0, 2'd2, 0, 8'h00, 8'h00);
        default: e = '0;
      endcase
      tests++;
      if (obs_m() !== e) begin
        fails++;
        $display("FAIL stale_finish cycle %0d: got %h, expected %h", c, obs_m(), e);
      end
      start = 1'b0;
      abort = (c == 4);
    end
    abort = 1'b0;
    $display("[TB] stale_finish: held init_finish advanced only after second run cycle");
  endtask

  task automatic test_isolation();
    logic [24:0] e;
    auto_eng = 1'b0;
    fin = '{1'b0, 1'b0, 1'b0};
    eng_addr = '{8'h10, 8'h55, 8'h77};
    eng_data = '{8'ha1, 8'hb2, 8'hc3};
    eng_wen  = '{1'b1, 1'b1, 1'b1};
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1:       e = pk(1, 0, 0, 0, 1, 0, 2'd1, 0, 8'h00, 8'h00);
        2:       e = pk(0, 0, 0, 0, 1, 0, 2'd1, 0, 8'h10, 8'ha1);
        3:       e = pk(0, 0, 0, 0, 1, 0, 2'd1, 1, 8'h10, 8'ha1);
        4:       e = pk(0, 0, 0, 0, 1, 0, 2'd1, 0, 8'h3c, 8'ha1);
        default: e = '0;
      endcase
      tests++;
      if (obs_m() !== e) begin
        fails++;
        $display("FAIL isolation cycle %0d: got %h, expected %h", c, obs_m(), e);
      end
      start = 1'b0;
      case (c)
        1: eng_wen[0] = 1'b0;
        2: eng_wen[0] = 1'b1;
        3: begin eng_wen[0] = 1'b0; eng_addr[0] = 8'h3c; end
        4: abort = 1'b1;
        default: abort = 1'b0;
      endcase
    end
    abort = 1'b0;
    $display("[TB] isolation: ksa requests kept off the RAM port during init");
  endtask

  task automatic test_abort_vs_finish();
    int gp;
    eng_dly = '{3, 3, 4};
    eng_cnt = '{0, 0, 0};
    auto_eng = 1'b1;
    gp = 1 + 4 + 4;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= gp + 4; c++) begin
      @(negedge clk);
      eng_update();
      start = 1'b0;
    end
    // prga_finish has just risen; abort arrives in the same cycle.
    abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (obs_m() !== 25'd0) begin
        fails++;
        $display("FAIL abort_step%0d: got %h, expected idle zeros", k, obs_m());
      end
      start = (k == 0);
      abort = (k == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    $display("[TB] abort: finish and start lost to abort, no done pulse");
  endtask

  task automatic test_timeout();
    logic [16:0] e, a;
    auto_eng = 1'b0;
    fin_t = '{1'b0, 1'b0, 1'b0};
    eng_addr = '{8'h11, 8'h22, 8'h33};
    eng_wen  = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    start_t = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 1)       e = {4'b1000, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
      else if (c <= 3)  e = {4'b0000, 1'b1, 1'b0, 2'd1, 1'b0, 8'h11};
      else if (c == 4)  e = {4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
      else if (c <= 20) e = {4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 8'h22};
      else if (c <= 23) e = {4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00};
      else              e = {4'b1000, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
      a = {init_start_t, ksa_start_t, prga_start_t, done_t, busy_t, error_t, phase_t,
           s_wen_t, s_addr_t};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL timeout cycle %0d: got %h, expected %h", c, a, e);
      end
      case (c)
        1:  start_t = 1'b0;
        3:  fin_t[0] = 1'b1;
        4:  fin_t[0] = 1'b0;
        21: abort_t = 1'b1;
        22: abort_t = 1'b0;
        23: start_t = 1'b1;
        24: begin start_t = 1'b0; abort_t = 1'b1; end
        default: ;
      endcase
    end
    @(negedge clk);
    abort_t = 1'b0;
    $display("[TB] timeout: ksa stalled, error raised, survived abort, cleared by start");
  endtask

  task automatic test_reset_mid_ksa();
    eng_dly = '{5, 40, 5};
    eng_cnt = '{0, 0, 0};
    auto_eng = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      eng_update();
      start = 1'b0;
    end
    tests++;
    if ({busy, phase} !== 3'b110) begin
      fails++;
      $display("FAIL reset_mid_ksa_pre: busy/phase got %b, expected 110", {busy, phase});
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({obs_m(), obs_t()} !== 50'd0) begin
      fails++;
      $display("FAIL reset_async: got %h/%h, expected all zero", obs_m(), obs_t());
    end
    @(negedge clk);
    tests++;
    if (obs_m() !== 25'd0) begin
      fails++;
      $display("FAIL reset_hold: got %h, expected all zero", obs_m());
    end
    reset_n = 1'b1;
    run_sequence(4, 6, 3, 1'b0, 1'b1, "after_reset");
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; start_t = 1'b0; abort_t = 1'b0;
    auto_eng = 1'b0;
    fin = '{1'b0, 1'b0, 1'b0};
    fin_t = '{1'b0, 1'b0, 1'b0};
    eng_addr = '{8'h00, 8'h00, 8'h00};
    eng_data = '{8'h00, 8'h00, 8'h00};
    eng_wen  = '{1'b0, 1'b0, 1'b0};
    eng_cnt = '{0, 0, 0};
    eng_dly = '{2, 2, 2};
    test_reset();
    test_normal_run();
    test_back_to_back();
    test_stale_finish();
    test_isolation();
    test_abort_vs_finish();
    test_timeout();
    test_reset_mid_ksa();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
